// File: rtl/alu_execute_unit.sv
// Execute stage with ADD/SUB in one cycle and an optional WIDTH-cycle shift-add multiplier.
// The multiplier is compiled in only when the macro ALU_EXEC_MUL_EN is defined.
module alu_execute_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             InValid,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic             InReady,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             IllegalOp,
    output logic             Busy
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;

`ifdef ALU_EXEC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`endif

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg, zero_next;
    logic             illegal_reg, illegal_next;

    logic             accept;
    logic             load_res;
    logic [WIDTH-1:0] res_val;
    logic             ill_val;

`ifdef ALU_EXEC_MUL_EN
    logic [WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] acc_step;

    // One partial product per cycle; multiplicand shifts left, multiplier shifts right.
    assign acc_step = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    assign Busy     = (state_reg == MUL);
`else
    assign Busy     = 1'b0;
`endif

    assign InReady   = (state_reg == IDLE) || ((state_reg == DONE) && OutReady);
    assign accept    = InValid && InReady;
    assign OutValid  = (state_reg == DONE);
    assign Result    = result_reg;
    assign Zero      = zero_reg;
    assign IllegalOp = illegal_reg;

    always_comb begin
        state_next   = state_reg;
        result_next  = result_reg;
        zero_next    = zero_reg;
        illegal_next = illegal_reg;
        load_res     = 1'b0;
        res_val      = '0;
        ill_val      = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
`endif

        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    // A new op in DONE also consumes the pending result on this edge.
                    case (ALUControl)
                        OP_ADD: begin
                            state_next = DONE;
                            load_res   = 1'b1;
                            res_val    = OperandA + OperandB;
                        end
                        OP_SUB: begin
                            state_next = DONE;
                            load_res   = 1'b1;
                            res_val    = OperandA - OperandB;
                        end
`ifdef ALU_EXEC_MUL_EN
                        OP_MUL: begin
                            state_next  = MUL;
                            mcand_next  = OperandA;
                            mplier_next = OperandB;
                            acc_next    = '0;
                            cnt_next    = '0;
                        end
`endif
                        default: begin
                            state_next = DONE;
                            load_res   = 1'b1;
                            res_val    = '0;
                            ill_val    = 1'b1;
                        end
                    endcase
                end else if ((state_reg == DONE) && OutReady) begin
                    state_next = IDLE;
                end
            end
`ifdef ALU_EXEC_MUL_EN
            MUL: begin
                acc_next    = acc_step;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                    load_res   = 1'b1;
                    res_val    = acc_step;
                end
            end
`endif
            default: state_next = IDLE;
        endcase

        // Zero and IllegalOp always move together with Result.
        if (load_res) begin
            result_next  = res_val;
            zero_next    = (res_val == '0);
            illegal_next = ill_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            result_reg  <= result_next;
            zero_reg    <= zero_next;
            illegal_reg <= illegal_next;
`ifdef ALU_EXEC_MUL_EN
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed scoreboard bench for alu_execute_unit; MUL expectations follow ALU_EXEC_MUL_EN.
module tb_alu_execute_unit;

    localparam int WIDTH = 32;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_BAD = 4'b0111;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             InValid = 1'b0;
    logic [3:0]       ALUControl = 4'b0000;
    logic [WIDTH-1:0] OperandA = '0;
    logic [WIDTH-1:0] OperandB = '0;
    logic             OutReady = 1'b0;
    logic             InReady;
    logic             OutValid;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             IllegalOp;
    logic             Busy;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ill;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;

    alu_execute_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .InValid   (InValid),
        .ALUControl(ALUControl),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .InReady   (InReady),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .Result    (Result),
        .Zero      (Zero),
        .IllegalOp (IllegalOp),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH-1:0] r;
        logic ill;
        ill = 1'b0;
        case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
`ifdef ALU_EXEC_MUL_EN
            OP_MUL: r = a * b;
`endif
            default: begin
                r   = '0;
                ill = 1'b1;
            end
        endcase
        e.res  = r;
        e.zero = (r == '0);
        e.ill  = ill;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single edge; the expected output enters the scoreboard.
    task automatic send(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
        InValid    = 1'b1;
        ALUControl = op;
        OperandA   = a;
        OperandB   = b;
        chk({tag, "_inready"}, 64'(InReady), 64'd1);
        sb.push_back(model(op, a, b));
        tick();
        InValid    = 1'b0;
        ALUControl = 4'($urandom);
        OperandA   = $urandom;
        OperandB   = $urandom;
    endtask

    // Output must be valid now; compare it against the oldest scoreboard entry.
    task automatic expect_out(input string tag);
        exp_t e;
        chk({tag, "_outvalid"}, 64'(OutValid), 64'd1);
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            last_exp = e;
            chk({tag, "_result"}, 64'(Result), 64'(e.res));
            chk({tag, "_zero"}, 64'(Zero), 64'(e.zero));
            chk({tag, "_illegal"}, 64'(IllegalOp), 64'(e.ill));
            $display("txn %s result=%08h zero=%0d illegal=%0d", tag, Result, Zero, IllegalOp);
        end
    endtask

    initial begin
        int cyc;
        int busy_cnt;
        logic ir_seen;
        logic ov_seen;

        // Reset state
        tick();
        tick();
        chk("rst_outvalid", 64'(OutValid), 64'd0);
        chk("rst_result", 64'(Result), 64'd0);
        chk("rst_zero", 64'(Zero), 64'd0);
        chk("rst_illegal", 64'(IllegalOp), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_inready", 64'(InReady), 64'd1);
        reset_n  = 1'b1;
        OutReady = 1'b1;

        // First op after release, one-cycle latency
        send("add", OP_ADD, 32'h0000_0005, 32'h0000_0003);
        expect_out("add");
        chk("add_busy", 64'(Busy), 64'd0);
        tick();
        chk("add_idle_outvalid", 64'(OutValid), 64'd0);

        // Ignored inputs while nothing is accepted
        repeat (3) begin
            ALUControl = 4'($urandom);
            OperandA   = $urandom;
            OperandB   = $urandom;
            tick();
            chk("idle_noaccept", 64'(OutValid), 64'd0);
        end

        // Back-to-back chain through DONE
        send("sub_wrap", OP_SUB, 32'h0000_0000, 32'h0000_0001);
        expect_out("sub_wrap");
        send("sub_zero", OP_SUB, 32'h0000_1234, 32'h0000_1234);
        expect_out("sub_zero");
        send("b2b_add", OP_ADD, 32'hFFFF_FFF0, 32'h0000_0020);
        expect_out("b2b_add");
        send("illegal", OP_BAD, 32'hDEAD_BEEF, 32'h1234_5678);
        expect_out("illegal");
        send("add_zero", OP_ADD, 32'h0000_0007, 32'hFFFF_FFF9);
        expect_out("add_zero");
        tick();
        chk("chain_idle", 64'(OutValid), 64'd0);

`ifdef ALU_EXEC_MUL_EN
        // Multiply with competing requests, operand churn and a stalled consumer
        send("mul", OP_MUL, 32'h0001_0001, 32'h0001_0001);
        chk("mul_busy_start", 64'(Busy), 64'd1);
        InValid    = 1'b1;
        ALUControl = OP_ADD;
        OutReady   = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        ir_seen = 1'b0;
        while (!OutValid && cyc < 100) begin
            if (Busy) busy_cnt++;
            if (InReady) ir_seen = 1'b1;
            OperandA = $urandom;
            OperandB = $urandom;
            tick();
            cyc++;
        end
        chk("mul_latency", 64'(cyc), 64'(WIDTH));
        chk("mul_busy_cycles", 64'(busy_cnt), 64'(WIDTH));
        chk("mul_inready_low", 64'(ir_seen), 64'd0);
        expect_out("mul");
        repeat (5) begin
            tick();
            chk("mul_hold_result", 64'(Result), 64'(last_exp.res));
            chk("mul_hold_valid", 64'(OutValid), 64'd1);
            chk("mul_hold_inready", 64'(InReady), 64'd0);
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        tick();
        chk("mul_consumed", 64'(OutValid), 64'd0);
        tick();
        chk("mul_no_ghost", 64'(OutValid), 64'd0);

        // Reset asserted at iteration 10 aborts the multiply
        send("mul_abort", OP_MUL, 32'h0000_0003, 32'h0000_0005);
        void'(sb.pop_back());
        repeat (10) tick();
        chk("abort_busy_before", 64'(Busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_outvalid", 64'(OutValid), 64'd0);
        chk("abort_result", 64'(Result), 64'd0);
        chk("abort_zero", 64'(Zero), 64'd0);
        chk("abort_illegal", 64'(IllegalOp), 64'd0);
        chk("abort_inready", 64'(InReady), 64'd1);
        tick();
        reset_n = 1'b1;
        ov_seen = 1'b0;
        repeat (40) begin
            tick();
            if (OutValid) ov_seen = 1'b1;
        end
        chk("abort_no_outvalid", 64'(ov_seen), 64'd0);
`else
        // Without the multiplier, MUL is an illegal op
        send("mul_illegal", OP_MUL, 32'h0001_0001, 32'h0001_0001);
        chk("mul_illegal_busy", 64'(Busy), 64'd0);
        expect_out("mul_illegal");
        tick();
        chk("mul_illegal_idle", 64'(OutValid), 64'd0);
`endif

        // Asynchronous reset while a result is pending
        send("pend", OP_ADD, 32'h0000_0100, 32'h0000_0023);
        expect_out("pend");
        OutReady = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("areset_outvalid", 64'(OutValid), 64'd0);
        chk("areset_result", 64'(Result), 64'd0);
        chk("areset_inready", 64'(InReady), 64'd1);
        tick();
        reset_n  = 1'b1;
        OutReady = 1'b1;

        // Recovery after reset
        send("recover", OP_SUB, 32'h0000_0010, 32'h0000_0004);
        expect_out("recover");
        tick();
        chk("recover_idle", 64'(OutValid), 64'd0);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
